// File: rtl/sc_fetch_pkg.sv
// Shared CPU definitions: PC mux select, fetch FSM states, fault codes, ALU ops.
package sc_fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [1:0] {
    PC_NOP    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_RSVD   = 2'b11
  } pc_mux_e;

  typedef enum logic [2:0] {
    S_RESET_HOLD = 3'd0,
    S_REQ        = 3'd1,
    S_WAIT       = 3'd2,
    S_ISSUE      = 3'd3,
    S_FAULT      = 3'd4
  } fetch_state_e;

  typedef enum logic [1:0] {
    FC_NONE     = 2'b00,
    FC_MISALIGN = 2'b01,
    FC_TIMEOUT  = 2'b10
  } fault_cause_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

endpackage

// File: rtl/sc_fetch_if.sv
// Instruction-memory request/response channel between fetch (master) and memory (slave).
interface sc_fetch_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data
  );
endinterface

// File: rtl/sc_fetch_next_pc.sv
// Next-PC selection from the execute-stage PC mux code, with alignment check.
module sc_next_pc
  import sc_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  branch,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  // Reserved code 11 falls through to sequential fetch; JALR clears bit 0.
  always_comb begin
    next_pc = pc + 32'd4;
    case (pc_mux_e'(branch))
      PC_BRANCH: next_pc = branch_target;
      PC_JUMP:   next_pc = jump_target & ~32'd1;
      default:   next_pc = pc + 32'd4;
    endcase
  end

  assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/sc_fetch.sv
// Single-cycle-core fetch unit: request, wait for word, hold it until execute resolves.
module sc_fetch
  import sc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned IMEM_TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  sc_fetch_if.master   imem,
  output logic [31:0]  instr,
  output logic [31:0]  instr_pc,
  output logic         instr_valid,
  input  logic         ex_done,
  input  logic [1:0]   branch,
  input  logic [31:0]  branch_target,
  input  logic [31:0]  jump_target,
  output logic         fault,
  output logic [1:0]   fault_cause
);

  localparam int CNT_W = (IMEM_TIMEOUT > 1) ? $clog2(IMEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IMEM_TIMEOUT - 1);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      instr_pc_q, instr_pc_d;
  fault_cause_e     cause_q, cause_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;

  logic [31:0] next_pc;
  logic        misaligned;
  logic        timeout;

  sc_next_pc u_next_pc (
    .pc            (pc_q),
    .branch        (branch),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .next_pc       (next_pc),
    .misaligned    (misaligned)
  );

  assign timeout = (wcnt_q == CNT_LAST);

  // State register; reset abandons any in-flight request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_RESET_HOLD;
    else     state_q <= state_d;
  end

  // Next-state: response wins over timeout on the final WAIT cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET_HOLD: state_d = S_REQ;
      S_REQ:        if (imem.imem_req_ready) state_d = S_WAIT;
      S_WAIT: begin
        if (imem.imem_resp_valid) state_d = S_ISSUE;
        else if (timeout)         state_d = S_FAULT;
      end
      S_ISSUE:      if (ex_done) state_d = misaligned ? S_FAULT : S_REQ;
      S_FAULT:      state_d = S_FAULT;
      default:      state_d = S_FAULT;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    imem.imem_req_valid = (state_q == S_REQ);
    instr_valid         = (state_q == S_ISSUE);
    fault               = (state_q == S_FAULT);
  end

  assign imem.imem_req_addr = pc_q;
  assign instr              = instr_q;
  assign instr_pc           = instr_pc_q;
  assign fault_cause        = cause_q;

  // Datapath next-state: capture word in WAIT, advance pc on ex_done in ISSUE.
  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    cause_d    = cause_q;
    wcnt_d     = wcnt_q;
    case (state_q)
      S_REQ: wcnt_d = '0;
      S_WAIT: begin
        if (imem.imem_resp_valid) begin
          instr_d    = imem.imem_resp_data;
          instr_pc_d = pc_q;
        end else if (timeout) begin
          cause_d = FC_TIMEOUT;
        end else begin
          wcnt_d = wcnt_q + CNT_W'(1);
        end
      end
      S_ISSUE: begin
        if (ex_done) begin
          pc_d = next_pc;  // kept even when misaligned, for fault diagnosis
          if (misaligned) cause_d = FC_MISALIGN;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      instr_pc_q <= RESET_PC;
      cause_q    <= FC_NONE;
      wcnt_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      cause_q    <= cause_d;
      wcnt_q     <= wcnt_d;
    end
  end

endmodule

// File: tb/tb_sc_fetch.sv
// Directed bench for sc_fetch: sequential fetch, stall, branch/jump, faults, reset, wrap.
module tb_sc_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_done;
  logic [1:0]  branch;
  logic [31:0] branch_target, jump_target;
  logic [31:0] instr, instr_pc;
  logic        instr_valid, fault;
  logic [1:0]  fault_cause;

  int checks = 0;
  int errors = 0;

  // memory model controls
  bit          mem_auto;
  bit          force_resp;
  logic [31:0] force_data;
  bit          rsp_fire;
  logic [31:0] rsp_addr;

  sc_fetch_if bus();

  sc_fetch #(.RESET_PC(32'h0000_0000), .IMEM_TIMEOUT(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem          (bus),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .ex_done       (ex_done),
    .branch        (branch),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .fault         (fault),
    .fault_cause   (fault_cause)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], 16'h0093};
  endfunction

  // Memory answers one cycle after an accepted request, or replays a forced response.
  always @(posedge clk) begin
    rsp_fire = bus.imem_req_valid && bus.imem_req_ready;
    rsp_addr = bus.imem_req_addr;
    #1;
    if (mem_auto) begin
      bus.imem_resp_valid = rsp_fire;
      bus.imem_resp_data  = rsp_fire ? mem_word(rsp_addr) : 32'h0;
    end else begin
      bus.imem_resp_valid = force_resp;
      bus.imem_resp_data  = force_data;
    end
  end

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valids: req_valid=%b instr_valid=%b want 0/0", bus.imem_req_valid, instr_valid);
    end
    checks++;
    if (fault !== 1'b0 || fault_cause !== 2'b00) begin
      errors++; $display("FAIL reset_fault: fault=%b cause=%b want 0/00", fault, fault_cause);
    end
    checks++;
    if (instr !== 32'h0000_0013 || instr_pc !== 32'h0 || bus.imem_req_addr !== 32'h0) begin
      errors++; $display("FAIL reset_regs: instr=%h instr_pc=%h addr=%h want 00000013/0/0", instr, instr_pc, bus.imem_req_addr);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL reset_hold: req_valid=%b want 0", bus.imem_req_valid);
    end
  endtask

  // 0x0 and 0x4 back-to-back; ISSUE at 0x0 uses reserved mux code 11.
  task automatic test_sequential;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      branch = 2'b00;
      checks++;
      if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'(4 * i) || instr_valid !== 1'b0) begin
        errors++; $display("FAIL seq_req%0d: valid=%b addr=%h ivalid=%b want 1/%h/0", i, bus.imem_req_valid, bus.imem_req_addr, instr_valid, 32'(4 * i));
      end
      @(negedge clk);
      checks++;
      if (bus.imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
        errors++; $display("FAIL seq_wait%0d: valid=%b ivalid=%b want 0/0", i, bus.imem_req_valid, instr_valid);
      end
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b1 || instr !== mem_word(32'(4 * i)) || instr_pc !== 32'(4 * i)) begin
        errors++; $display("FAIL seq_issue%0d: ivalid=%b instr=%h pc=%h want 1/%h/%h", i, instr_valid, instr, instr_pc, mem_word(32'(4 * i)), 32'(4 * i));
      end
      if (i == 0) begin
        branch = 2'b11; branch_target = 32'h100; jump_target = 32'h200;
      end
    end
    bus.imem_req_ready = 1'b0;
  endtask

  task automatic test_stall;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8 || instr_valid !== 1'b0) begin
        errors++; $display("FAIL stall%0d: valid=%b addr=%h ivalid=%b want 1/00000008/0", i, bus.imem_req_valid, bus.imem_req_addr, instr_valid);
      end
    end
    bus.imem_req_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h8 || instr !== mem_word(32'h8)) begin
      errors++; $display("FAIL stall_issue: ivalid=%b pc=%h instr=%h want 1/00000008/%h", instr_valid, instr_pc, instr, mem_word(32'h8));
    end
  endtask

  task automatic test_branch;
    repeat (6) @(negedge clk);  // 0xC round trip, then ISSUE of 0x10
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h10) begin
      errors++; $display("FAIL br_at10: ivalid=%b pc=%h want 1/00000010", instr_valid, instr_pc);
    end
    branch = 2'b01; branch_target = 32'h40;
    @(negedge clk);
    branch = 2'b00;
    checks++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h40) begin
      errors++; $display("FAIL br_taken: valid=%b addr=%h want 1/00000040", bus.imem_req_valid, bus.imem_req_addr);
    end
    repeat (2) @(negedge clk);
    branch = 2'b01; branch_target = 32'h10;
    @(negedge clk);
    branch = 2'b00;
    repeat (2) @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h10) begin
      errors++; $display("FAIL jmp_at10: ivalid=%b pc=%h want 1/00000010", instr_valid, instr_pc);
    end
    branch = 2'b10; jump_target = 32'h81;
    @(negedge clk);
    branch = 2'b00;
    checks++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h80 || fault !== 1'b0) begin
      errors++; $display("FAIL jump: valid=%b addr=%h fault=%b want 1/00000080/0", bus.imem_req_valid, bus.imem_req_addr, fault);
    end
  endtask

  task automatic test_misaligned;
    repeat (2) @(negedge clk);
    branch = 2'b01; branch_target = 32'h42;
    @(negedge clk);
    branch = 2'b00;
    checks++;
    if (fault !== 1'b1 || fault_cause !== 2'b01 || bus.imem_req_addr !== 32'h42) begin
      errors++; $display("FAIL misalign: fault=%b cause=%b addr=%h want 1/01/00000042", fault, fault_cause, bus.imem_req_addr);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || fault !== 1'b1) begin
        errors++; $display("FAIL misalign_hold%0d: valid=%b ivalid=%b fault=%b want 0/0/1", i, bus.imem_req_valid, instr_valid, fault);
      end
    end
  endtask

  task automatic test_timeout;
    mem_auto = 1'b0; force_resp = 1'b0; force_data = 32'h0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (fault !== 1'b0 || fault_cause !== 2'b00) begin
      errors++; $display("FAIL to_reset: fault=%b cause=%b want 0/00", fault, fault_cause);
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if (fault !== 1'b0 || instr_valid !== 1'b0 || bus.imem_req_valid !== 1'b0) begin
        errors++; $display("FAIL to_wait%0d: fault=%b ivalid=%b valid=%b want 0/0/0", i, fault, instr_valid, bus.imem_req_valid);
      end
    end
    @(negedge clk);
    checks++;
    if (fault !== 1'b1 || fault_cause !== 2'b10 || bus.imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL timeout: fault=%b cause=%b valid=%b want 1/10/0", fault, fault_cause, bus.imem_req_valid);
    end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0 || fault !== 1'b0) begin
      errors++; $display("FAIL to_resume: valid=%b addr=%h fault=%b want 1/00000000/0", bus.imem_req_valid, bus.imem_req_addr, fault);
    end
  endtask

  // Reset mid-WAIT, then a stale response must not be taken before the next request fires.
  task automatic test_late_resp;
    @(negedge clk);  // request fired, now in WAIT
    rst = 1'b1;
    #1;
    checks++;
    if (bus.imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0000_0013) begin
      errors++; $display("FAIL rst_midwait: valid=%b ivalid=%b instr=%h want 0/0/00000013", bus.imem_req_valid, instr_valid, instr);
    end
    bus.imem_req_ready = 1'b0; force_resp = 1'b1; force_data = 32'hDEAD_BEEF;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b0 || instr !== 32'h0000_0013) begin
        errors++; $display("FAIL late_resp%0d: ivalid=%b instr=%h want 0/00000013", i, instr_valid, instr);
      end
    end
    force_resp = 1'b0; mem_auto = 1'b1; bus.imem_req_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1 || instr !== mem_word(32'h0) || instr_pc !== 32'h0) begin
      errors++; $display("FAIL late_refetch: ivalid=%b instr=%h pc=%h want 1/%h/0", instr_valid, instr, instr_pc, mem_word(32'h0));
    end
  endtask

  task automatic test_wrap;
    branch = 2'b10; jump_target = 32'hFFFF_FFFC;
    @(negedge clk);
    branch = 2'b00;
    checks++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_top: valid=%b addr=%h want 1/fffffffc", bus.imem_req_valid, bus.imem_req_addr);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_issue: ivalid=%b pc=%h want 1/fffffffc", instr_valid, instr_pc);
    end
    @(negedge clk);
    checks++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0 || fault !== 1'b0) begin
      errors++; $display("FAIL wrap: valid=%b addr=%h fault=%b want 1/00000000/0", bus.imem_req_valid, bus.imem_req_addr, fault);
    end
  endtask

  initial begin
    rst = 1'b1; ex_done = 1'b1; branch = 2'b00;
    branch_target = 32'h0; jump_target = 32'h0;
    bus.imem_req_ready = 1'b1;
    mem_auto = 1'b1; force_resp = 1'b0; force_data = 32'h0;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_misaligned();
    test_timeout();
    test_late_resp();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sc_fetch.md
SC_FETCH -- requirements
Module: sc_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-002 The block SHALL have parameter IMEM_TIMEOUT, default 16, meaning the maximum cycles spent in WAIT before raising a fault.
REQ-003 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  instruction fetch request.
- imem_req_addr  out  32  fetch address, equal to pc.
- imem_req_ready  in  1  memory accepts the request.
- imem_resp_valid  in  1  instruction word returned.
- imem_resp_data  in  32  instruction word.
- instr  out  32  held instruction for decode/execute.
- instr_pc  out  32  PC of the held instruction.
- instr_valid  out  1  instr/instr_pc are valid.
- ex_done  in  1  execute stage has resolved the held instruction this cycle.
- branch  in  2  PC_MUX_ENUM from execute: NOP=00, BRANCH=01, JUMP=10, 11 reserved.
- branch_target  in  32  pc+imm for a taken conditional branch.
- jump_target  in  32  ALU result for JAL/JALR.
- fault  out  1  sticky fault flag.
- fault_cause  out  2  00 none, 01 misaligned target, 10 imem timeout.

Function
REQ-004 The block SHALL implement FSM states RESET_HOLD, REQ, WAIT, ISSUE and FAULT.
REQ-005 RESET_HOLD SHALL last exactly one cycle after rst deasserts, then move to REQ.
REQ-006 In REQ, imem_req_valid SHALL be 1 and imem_req_addr SHALL equal pc; the request fires when valid and ready are both high, and the FSM then moves to WAIT.
REQ-007 imem_req_addr SHALL remain stable while imem_req_valid=1 and imem_req_ready=0.
REQ-008 In WAIT, imem_resp_valid=1 SHALL latch instr<=imem_resp_data and instr_pc<=pc, and move to ISSUE.
REQ-009 A response is accepted only in WAIT; imem_resp_valid outside WAIT SHALL be ignored.
REQ-010 A WAIT counter SHALL reset on entry to WAIT; reaching IMEM_TIMEOUT cycles without a response SHALL move to FAULT with fault_cause=10.
REQ-011 instr_valid SHALL be 1 exactly while in ISSUE; instr and instr_pc SHALL hold until ex_done.
REQ-012 In ISSUE with ex_done=1, the next pc SHALL be chosen by branch: 00 or 11 -> pc+4 (mod 2^32); 01 -> branch_target; 10 -> {jump_target[31:1],1'b0}.
REQ-013 After the next pc is selected, the FSM SHALL move to REQ on the following cycle, giving a minimum of 3 cycles per instruction (REQ, WAIT, ISSUE) when ready and response are immediate.
REQ-014 A selected next pc with bits [1:0] != 00 SHALL move to FAULT with fault_cause=01; pc SHALL retain the faulting target.
REQ-015 ex_done outside ISSUE SHALL be ignored; branch, branch_target and jump_target SHALL be sampled only when ex_done=1 in ISSUE.
REQ-016 FAULT SHALL be terminal until rst; in FAULT: fault=1, imem_req_valid=0, instr_valid=0.
REQ-017 pc+4 SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000 with no fault.

Reset
REQ-018 While rst=1, the block SHALL hold: pc=RESET_PC, state=RESET_HOLD, instr=32'h0000_0013 (NOP), instr_pc=RESET_PC, instr_valid=0, imem_req_valid=0, fault=0, fault_cause=00, WAIT counter=0.
REQ-019 An assertion of rst mid-operation, in any state, SHALL abandon any outstanding request; a late imem_resp_valid arriving after reset SHALL be ignored until the next request fires.

Structure
REQ-020 PC_MUX_ENUM, the FSM state encoding, the fault_cause codes and the NOP instruction constant SHALL live in the shared CPU package/include alongside ALU_OP_ENUM.
REQ-021 Next-PC selection SHALL be one combinational sub-module, sc_next_pc (inputs: pc, branch, branch_target, jump_target; outputs: next_pc, misaligned).

Verification
REQ-022 Reset release, imem_req_ready=1 and 1-cycle responses, branch=00 -> imem_req_addr sequence 0x0, 0x4, 0x8, with instr_valid high one cycle in each 3.
REQ-023 imem_req_ready held 0 for 5 cycles at pc=0x8 -> imem_req_addr stays 0x8 and the FSM stays in REQ.
REQ-024 At instr_pc=0x10: branch=01 with branch_target=0x40 -> next request addr 0x40; branch=10 with jump_target=0x81 -> addr 0x80.
REQ-025 branch=01 with branch_target=0x42 -> fault=1, fault_cause=01, no further imem_req_valid.
REQ-026 No response for IMEM_TIMEOUT=16 cycles -> fault_cause=10; rst pulse -> pc=RESET_PC and fetching resumes.
REQ-027 pc=0xFFFF_FFFC with branch=00 -> next addr 0x0, no fault.
